// File: rtl/hwag_coil_scheduler_if.sv
// Host register bus of the coil scheduler: angle writes, write status and commit handshake.
interface hwag_coil_scheduler_if #(
    parameter int unsigned ANGLE_W = 16
) ();
    localparam int unsigned CH_W = 3;

    logic               wr_en;
    logic [CH_W-1:0]    wr_ch;
    logic               wr_sel;
    logic [ANGLE_W-1:0] wr_data;
    logic               wr_ack;
    logic               wr_err;
    logic               commit;
    logic               commit_pending;

    modport master (
        output wr_en, wr_ch, wr_sel, wr_data, commit,
        input  wr_ack, wr_err, commit_pending
    );

    modport slave (
        input  wr_en, wr_ch, wr_sel, wr_data, commit,
        output wr_ack, wr_err, commit_pending
    );
endinterface

// File: rtl/hwag_coil_scheduler.sv
// Ignition coil scheduler: double-buffered on/off angles per channel, committed at the gap
// point and compared against the descending HWAG angle to drive each coil.
module hwag_coil_scheduler #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned ANGLE_W   = 16,
    parameter int unsigned ANGLE_MAX = 3839
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hwag_start,
    input  logic                 gap_point,
    input  logic [ANGLE_W-1:0]   angle,
    input  logic                 angle_step,
    hwag_coil_scheduler_if.slave host,
    output logic [CHANNELS-1:0]  coil,
    output logic [CHANNELS-1:0]  dwell_err
);
    localparam int unsigned CH_W = 3;

    typedef enum logic {OFF = 1'b0, ON = 1'b1} coil_state_e;

    logic [ANGLE_W-1:0] shadow_on  [CHANNELS];
    logic [ANGLE_W-1:0] shadow_off [CHANNELS];
    logic [ANGLE_W-1:0] active_on  [CHANNELS];
    logic [ANGLE_W-1:0] active_off [CHANNELS];

    coil_state_e         state_q [CHANNELS];
    coil_state_e         state_d [CHANNELS];
    logic [CHANNELS-1:0] gap_seen_q;
    logic [CHANNELS-1:0] gap_seen_d;
    logic [CHANNELS-1:0] dwell_err_d;

    logic wr_ok_c;
    logic apply_c;

    assign wr_ok_c = (32'(host.wr_ch) < CHANNELS) && (host.wr_data <= ANGLE_W'(ANGLE_MAX));
    assign apply_c = gap_point && host.commit_pending;

    // Host writes, commit handshake and the shadow->active transfer at the gap point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host.wr_ack         <= 1'b0;
            host.wr_err         <= 1'b0;
            host.commit_pending <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_on[i]  <= '0;
                shadow_off[i] <= '0;
                active_on[i]  <= '0;
                active_off[i] <= '0;
            end
        end else begin
            host.wr_ack         <= host.wr_en && wr_ok_c;
            host.wr_err         <= host.wr_en && !wr_ok_c;
            host.commit_pending <= host.commit || (host.commit_pending && !apply_c);
            for (int i = 0; i < CHANNELS; i++) begin
                // Nonblocking copy takes the shadow as it stood before a same-cycle write
                if (apply_c) begin
                    active_on[i]  <= shadow_on[i];
                    active_off[i] <= shadow_off[i];
                end
                if (host.wr_en && wr_ok_c && host.wr_ch == CH_W'(i)) begin
                    if (host.wr_sel) shadow_off[i] <= host.wr_data;
                    else             shadow_on[i]  <= host.wr_data;
                end
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_seen_q <= '0;
            dwell_err  <= '0;
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= OFF;
        end else begin
            gap_seen_q <= gap_seen_d;
            dwell_err  <= dwell_err_d;
            for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
        end
    end

    // Per-channel next state: start-loss and dwell guard take priority over the off-angle
    always_comb begin
        gap_seen_d  = gap_seen_q;
        dwell_err_d = dwell_err;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                OFF: begin
                    gap_seen_d[i] = 1'b0;
                    if (hwag_start && angle_step && angle == active_on[i] &&
                        active_on[i] != active_off[i]) begin
                        state_d[i] = ON;
                    end
                end
                ON: begin
                    if (!hwag_start) begin
                        state_d[i] = OFF;
                    end else if (gap_point && gap_seen_q[i]) begin
                        state_d[i]     = OFF;
                        dwell_err_d[i] = 1'b1;
                    end else if (angle_step && angle == active_off[i]) begin
                        state_d[i] = OFF;
                    end else if (gap_point) begin
                        gap_seen_d[i] = 1'b1;
                    end
                end
                default: state_d[i] = OFF;
            endcase
        end
    end

    always_comb begin
        coil = '0;
        for (int i = 0; i < CHANNELS; i++) coil[i] = (state_q[i] == ON);
    end
endmodule

// File: tb/tb_hwag_coil_scheduler.sv
// Bench for hwag_coil_scheduler: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the scheduling rules.
module tb_hwag_coil_scheduler;
    localparam int CH  = 4;
    localparam int AW  = 16;
    localparam int MAX = 3839;

    logic          clk = 1'b0;
    logic          rst;
    logic          hwag_start;
    logic          gap_point;
    logic [AW-1:0] angle;
    logic          angle_step;
    logic [CH-1:0] coil;
    logic [CH-1:0] dwell_err;

    hwag_coil_scheduler_if #(.ANGLE_W(AW)) host ();

    hwag_coil_scheduler #(.CHANNELS(CH), .ANGLE_W(AW), .ANGLE_MAX(MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .hwag_start (hwag_start),
        .gap_point  (gap_point),
        .angle      (angle),
        .angle_step (angle_step),
        .host       (host),
        .coil       (coil),
        .dwell_err  (dwell_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // bench-side stimulus state
    int cur      = 0;
    bit start_g  = 1'b1;
    int skip_ang = -1;
    bit rnd      = 1'b0;
    bit wen_g    = 1'b0;
    int wch_g    = 0;
    bit wsel_g   = 1'b0;
    int wdat_g   = 0;
    bit cmt_g    = 1'b0;

    // reference model: the programmer's view of the block
    int m_sh  [8][2];
    int m_act [CH][2];
    bit m_on  [CH];
    int m_gaps[CH];
    bit m_derr[CH];
    bit m_pend, m_ack, m_err;

    function automatic void model_reset();
        for (int c = 0; c < 8; c++) begin m_sh[c][0] = 0; m_sh[c][1] = 0; end
        for (int c = 0; c < CH; c++) begin
            m_act[c][0] = 0; m_act[c][1] = 0;
            m_on[c] = 1'b0; m_gaps[c] = 0; m_derr[c] = 1'b0;
        end
        m_pend = 1'b0; m_ack = 1'b0; m_err = 1'b0;
    endfunction

    function automatic void model_clock(input bit st, input bit gp, input bit stp, input int ang,
                                        input bit wen, input int wch, input bit wsel,
                                        input int wdat, input bit cmt);
        bit ok;
        ok    = (wch < CH) && (wdat <= MAX);
        m_ack = wen && ok;
        m_err = wen && !ok;
        for (int c = 0; c < CH; c++) begin
            if (m_on[c]) begin
                if (!st) m_on[c] = 1'b0;
                else if (gp && m_gaps[c] >= 1) begin m_on[c] = 1'b0; m_derr[c] = 1'b1; end
                else if (stp && ang == m_act[c][1]) m_on[c] = 1'b0;
                else if (gp) m_gaps[c]++;
            end else if (st && stp && ang == m_act[c][0] && m_act[c][0] != m_act[c][1]) begin
                m_on[c]   = 1'b1;
                m_gaps[c] = 0;
            end
        end
        if (gp && m_pend)
            for (int c = 0; c < CH; c++) begin m_act[c][0] = m_sh[c][0]; m_act[c][1] = m_sh[c][1]; end
        m_pend = cmt || (m_pend && !gp);
        if (wen && ok) m_sh[wch][wsel] = wdat;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        logic [CH-1:0] e_coil, e_derr;
        for (int c = 0; c < CH; c++) begin e_coil[c] = m_on[c]; e_derr[c] = m_derr[c]; end
        chk({where, ".wr_ack"}, 32'(host.wr_ack), 32'(m_ack));
        chk({where, ".wr_err"}, 32'(host.wr_err), 32'(m_err));
        chk({where, ".commit_pending"}, 32'(host.commit_pending), 32'(m_pend));
        chk({where, ".coil"}, 32'(coil), 32'(e_coil));
        chk({where, ".dwell_err"}, 32'(dwell_err), 32'(e_derr));
    endtask

    // One clock: drive inputs, clock, update the model, compare everything
    task automatic cyc(input bit gp, input bit stp, input int ang);
        hwag_start    = start_g;
        gap_point     = gp;
        angle_step    = stp;
        angle         = AW'(ang);
        host.wr_en    = wen_g;
        host.wr_ch    = 3'(wch_g);
        host.wr_sel   = wsel_g;
        host.wr_data  = AW'(wdat_g);
        host.commit   = cmt_g;
        @(posedge clk);
        model_clock(start_g, gp, stp, ang, wen_g, wch_g, wsel_g, wdat_g, cmt_g);
        #1;
        check_all("cyc");
        wen_g = 1'b0;
        cmt_g = 1'b0;
    endtask

    task automatic wr(input int ch, input bit sel, input int data);
        wen_g = 1'b1; wch_g = ch; wsel_g = sel; wdat_g = data;
        cyc(1'b0, 1'b0, cur);
    endtask

    task automatic do_commit();
        cmt_g = 1'b1;
        cyc(1'b0, 1'b0, cur);
    endtask

    // Advance the descending angle n ticks; the gap point coincides with the step onto MAX
    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            int nx;
            bit stp;
            nx = (cur == 0) ? MAX : cur - 1;
            if ($urandom_range(7) == 0) cyc(1'b0, 1'b0, cur);
            stp = (nx != skip_ang);
            if (rnd) begin
                start_g = ($urandom_range(511) != 0);
                if ($urandom_range(15) == 0) stp = 1'b0;
                if ($urandom_range(63) == 0) begin
                    wen_g = 1'b1; wch_g = $urandom_range(7); wsel_g = 1'($urandom_range(1));
                    wdat_g = (($urandom_range(3) == 0) ? $urandom_range(4200) : $urandom_range(MAX));
                end
                if ($urandom_range(255) == 0) cmt_g = 1'b1;
            end
            cur = nx;
            cyc(nx == MAX, stp, nx);
        end
    endtask

    task automatic adv_to(input int target);
        adv((cur - target + MAX + 1) % (MAX + 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hwag_start = 1'b0; gap_point = 1'b0; angle_step = 1'b0; angle = AW'(cur);
        host.wr_en = 1'b0; host.wr_ch = 3'd0; host.wr_sel = 1'b0; host.wr_data = '0; host.commit = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // basic dwell on ch0: 1000 -> 900
        wr(0, 1'b0, 1000);
        chk("ch0_on_ack", 32'(host.wr_ack), 32'd1);
        wr(0, 1'b1, 900);
        chk("ch0_off_ack", 32'(host.wr_ack), 32'd1);
        do_commit();
        chk("pending_set", 32'(host.commit_pending), 32'd1);
        adv(1);
        chk("pending_clear", 32'(host.commit_pending), 32'd0);
        adv_to(1001);
        chk("ch0_before_on", 32'(coil[0]), 32'd0);
        adv_to(1000);
        chk("ch0_rise", 32'(coil[0]), 32'd1);
        adv_to(901);
        chk("ch0_hold", 32'(coil[0]), 32'd1);
        adv_to(900);
        chk("ch0_fall", 32'(coil[0]), 32'd0);

        // rejected writes
        wr(1, 1'b0, 3840);
        chk("range_err", 32'(host.wr_err), 32'd1);
        chk("range_noack", 32'(host.wr_ack), 32'd0);
        wr(5, 1'b0, 100);
        chk("chan_err", 32'(host.wr_err), 32'd1);

        // ch1 dwell through the wrap
        wr(1, 1'b0, 100);
        wr(1, 1'b1, 3700);
        do_commit();
        adv_to(MAX);
        adv_to(50);
        chk("ch1_on", 32'(coil[1]), 32'd1);
        adv_to(3800);
        chk("ch1_wrap", 32'(coil[1]), 32'd1);
        adv_to(3600);
        chk("ch1_off", 32'(coil[1]), 32'd0);

        // loss of hwag_start while ch2 charges
        wr(2, 1'b0, 2000);
        wr(2, 1'b1, 1000);
        do_commit();
        adv_to(MAX);
        adv_to(1500);
        chk("ch2_on", 32'(coil[2]), 32'd1);
        start_g = 1'b0;
        cyc(1'b0, 1'b0, cur);
        chk("ch2_start_drop", 32'(coil[2]), 32'd0);
        start_g = 1'b1;
        adv_to(1200);
        chk("ch2_stay_off", 32'(coil[2]), 32'd0);
        adv_to(1900);
        chk("ch2_rearm", 32'(coil[2]), 32'd1);

        // ch3 disabled (on == off) never charges
        wr(3, 1'b1, 4000);
        chk("ch3_off_err", 32'(host.wr_err), 32'd1);
        wr(3, 1'b0, 500);
        wr(3, 1'b1, 500);
        do_commit();
        adv_to(MAX);
        adv_to(400);
        chk("ch3_disabled", 32'(coil[3]), 32'd0);

        // dwell guard: off angle never stepped, second gap forces ch3 off
        wr(3, 1'b1, 300);
        do_commit();
        skip_ang = 300;
        adv_to(MAX);
        adv_to(450);
        chk("ch3_on", 32'(coil[3]), 32'd1);
        adv_to(MAX);
        chk("ch3_one_gap", 32'(coil[3]), 32'd1);
        chk("ch3_no_err_yet", 32'(dwell_err[3]), 32'd0);
        adv(MAX + 1);
        chk("ch3_guard_off", 32'(coil[3]), 32'd0);
        chk("ch3_dwell_err", 32'(dwell_err[3]), 32'd1);
        skip_ang = -1;
        adv_to(3000);
        chk("ch3_err_sticky", 32'(dwell_err[3]), 32'd1);

        // commit with a write on the applying gap cycle
        wr(0, 1'b0, 1100);
        do_commit();
        adv_to(0);
        wen_g = 1'b1; wch_g = 0; wsel_g = 1'b0; wdat_g = 1200;
        adv(1);
        adv_to(1150);
        chk("ch0_old_shadow_off", 32'(coil[0]), 32'd0);
        adv_to(1050);
        chk("ch0_old_shadow_on", 32'(coil[0]), 32'd1);
        do_commit();
        adv_to(MAX);
        adv_to(1150);
        chk("ch0_new_shadow_on", 32'(coil[0]), 32'd1);

        // reset clears the sticky error
        do_reset();
        chk("err_cleared", 32'(dwell_err), 32'd0);

        // randomized host traffic, start drops and gated steps
        wr(0, 1'b0, 1000);
        wr(0, 1'b1, 900);
        wr(1, 1'b0, 100);
        wr(1, 1'b1, 3700);
        do_commit();
        rnd = 1'b1;
        adv(3 * (MAX + 1));
        rnd = 1'b0;
        start_g = 1'b1;
        adv(16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
